dpll_search_ctrl: RTL and testbench

- Top-level DPLL sequencer for the hardware SAT solver. Owns the formula stack of formula_stack_size entries.
- Picks decision literals, drives the external formula-simplification datapath over a req/ack handshake, and backtracks on conflict.
- Reports SAT with a model, UNSAT, or an error.
- Uses the common package types: lit, formula, formula_array; literal numbers run 1..number_literal, and 0 is invalid.

---
 rtl/dpll_search_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_dpll_search_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpll_search_ctrl.sv
// Shared SAT-solver types plus the DPLL search sequencer.
// The sequencer keeps a stack of (formula, decision literal, tried) entries,
// drives an external simplifier over req/ack and backtracks on conflicts.

package common;
  localparam int number_literal     = 6;
  localparam int number_clauses     = 8;
  localparam int formula_stack_size = 5;

  localparam int LIT_NUM_W     = $clog2(number_literal + 1);
  localparam int CLAUSE_LEN_W  = $clog2(number_literal + 1);
  localparam int FORMULA_LEN_W = $clog2(number_clauses + 1);

  // val=1 means the positive literal x_num, val=0 means its negation
  typedef struct packed {
    logic [LIT_NUM_W-1:0] num;
    logic                 val;
  } lit;

  typedef struct packed {
    logic [CLAUSE_LEN_W-1:0] len;
    lit [number_literal-1:0] lits;
  } clause;

  typedef struct packed {
    logic [FORMULA_LEN_W-1:0]   len;
    clause [number_clauses-1:0] clauses;
  } formula;

  typedef formula formula_array [formula_stack_size];

  localparam formula zero_formula = '0;
endpackage

module dpll_search_ctrl
  import common::*;
#(
  parameter int STAT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  formula                  formula_in,
  output logic                    simp_req,
  output formula                  simp_formula,
  output lit                      simp_lit,
  input  logic                    simp_ack,
  input  formula                  simp_result,
  input  logic                    simp_conflict,
  output logic                    busy,
  output logic                    done,
  output logic                    sat,
  output logic                    err,
  output logic [number_literal:0] model_val,
  output logic [number_literal:0] model_set,
  output logic [STAT_W-1:0]       decisions
);

  localparam int SP_W = $clog2(formula_stack_size + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DECIDE,
    S_REQ,
    S_WAIT,
    S_BACKTRACK,
    S_DONE
  } state_t;

  state_t          state;
  formula          cur;
  logic [SP_W-1:0] sp;
  formula_array    stack_f;
  lit              stack_l [formula_stack_size];
  logic            stack_t [formula_stack_size];

  logic                    cur_has_empty;
  logic [SP_W-1:0]         top_idx;
  lit                      cand;
  logic                    cand_bad;
  logic [number_literal:0] model_set_n;
  logic [number_literal:0] model_val_n;

  // Detect an empty clause among the live clauses of the current formula
  always_comb begin
    cur_has_empty = 1'b0;
    for (int i = 0; i < number_clauses; i++) begin
      if ((FORMULA_LEN_W'(i) < cur.len) && (cur.clauses[i].len == '0)) begin
        cur_has_empty = 1'b1;
      end
    end
  end

  // Top-of-stack index and the next decision candidate (first literal, tried true first)
  always_comb begin
    top_idx  = (sp == '0) ? '0 : sp - 1'b1;
    cand.num = cur.clauses[0].lits[0].num;
    cand.val = 1'b1;
    cand_bad = (cand.num == '0) || (cand.num > LIT_NUM_W'(number_literal));
  end

  // Model implied by the live stack entries; bit 0 never refers to a literal
  always_comb begin
    model_set_n = '0;
    model_val_n = '0;
    for (int k = 0; k < formula_stack_size; k++) begin
      if (SP_W'(k) < sp) begin
        model_set_n[stack_l[k].num] = 1'b1;
        model_val_n[stack_l[k].num] = stack_l[k].val;
      end
    end
    model_set_n[0] = 1'b0;
    model_val_n[0] = 1'b0;
  end

  // Search sequencer with all outputs registered; simp_req never depends on simp_ack combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cur          <= zero_formula;
      sp           <= '0;
      for (int k = 0; k < formula_stack_size; k++) begin
        stack_f[k] <= zero_formula;
        stack_l[k] <= '0;
        stack_t[k] <= 1'b0;
      end
      simp_req     <= 1'b0;
      simp_formula <= zero_formula;
      simp_lit     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat          <= 1'b0;
      err          <= 1'b0;
      model_val    <= '0;
      model_set    <= '0;
      decisions    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cur       <= formula_in;
            sp        <= '0;
            decisions <= '0;
            model_val <= '0;
            model_set <= '0;
            sat       <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (cur.len == '0) begin
            state     <= S_DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            sat       <= 1'b1;
            model_set <= model_set_n;
            model_val <= model_val_n;
          end else if (cur_has_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            sat   <= 1'b0;
          end else begin
            state <= S_DECIDE;
          end
        end

        S_DECIDE: begin
          if (cand_bad || (sp == SP_W'(formula_stack_size))) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            err   <= 1'b1;
            sat   <= 1'b0;
          end else begin
            stack_f[sp] <= cur;
            stack_l[sp] <= cand;
            stack_t[sp] <= 1'b0;
            sp          <= sp + 1'b1;
            state       <= S_REQ;
          end
        end

        S_REQ: begin
          simp_formula <= stack_f[top_idx];
          simp_lit     <= stack_l[top_idx];
          simp_req     <= 1'b1;
          if (decisions != '1) begin
            decisions <= decisions + 1'b1;
          end
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (simp_ack) begin
            simp_req <= 1'b0;
            if (simp_conflict) begin
              state <= S_BACKTRACK;
            end else if (simp_result.len == '0) begin
              state     <= S_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              sat       <= 1'b1;
              model_set <= model_set_n;
              model_val <= model_val_n;
            end else begin
              cur   <= simp_result;
              state <= S_LOAD;
            end
          end
        end

        S_BACKTRACK: begin
          if (sp == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            sat   <= 1'b0;
          end else if (!stack_t[top_idx]) begin
            stack_t[top_idx]     <= 1'b1;
            stack_l[top_idx].val <= ~stack_l[top_idx].val;
            state                <= S_REQ;
          end else begin
            sp <= sp - 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpll_search_ctrl.sv
// Self-checking bench for dpll_search_ctrl: the bench plays the simplifier and
// predicts each search with a depth-first reference solver over formula values.

module tb_dpll_search_ctrl;
  import common::*;

  localparam int LIMIT = 3000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  formula                  formula_in;
  logic                    simp_req;
  formula                  simp_formula;
  lit                      simp_lit;
  logic                    simp_ack;
  formula                  simp_result;
  logic                    simp_conflict;
  logic                    busy, done, sat, err;
  logic [number_literal:0] model_val, model_set;
  logic [15:0]             decisions;

  int checks   = 0;
  int failures = 0;

  // responder control: 0 silent, 1 behavioural simplifier, 2 identity (never removes anything)
  int resp_mode  = 1;
  int fixed_lat  = -1;
  int force_cnt  = 0;
  int force_done = 0;

  // protocol monitor counters (only the monitor writes them)
  int req_rises  = 0;
  int proto_viol = 0;

  // reference results
  int                      ref_decisions;
  logic                    ref_sat, ref_err, ref_trivial;
  logic [number_literal:0] ref_set, ref_val;
  int                      path_num [8];
  int                      path_val [8];

  formula fb;

  dpll_search_ctrl #(.STAT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .formula_in(formula_in),
    .simp_req(simp_req), .simp_formula(simp_formula), .simp_lit(simp_lit),
    .simp_ack(simp_ack), .simp_result(simp_result), .simp_conflict(simp_conflict),
    .busy(busy), .done(done), .sat(sat), .err(err),
    .model_val(model_val), .model_set(model_set), .decisions(decisions)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Simplification by the rules: drop satisfied clauses, drop false literals, compact
  function automatic void bench_simplify(input formula f, input int n, input int v,
                                         output formula r, output logic conf);
    clause c;
    int    m, k;
    logic  satisfied;
    r = '0; conf = 1'b0; k = 0;
    for (int i = 0; i < int'(f.len); i++) begin
      c = '0; m = 0; satisfied = 1'b0;
      for (int j = 0; j < int'(f.clauses[i].len); j++) begin
        if (int'(f.clauses[i].lits[j].num) == n) begin
          if (int'(f.clauses[i].lits[j].val) == v) satisfied = 1'b1;
        end else begin
          c.lits[m] = f.clauses[i].lits[j];
          m++;
        end
      end
      if (!satisfied) begin
        c.len = CLAUSE_LEN_W'(m);
        if (m == 0) conf = 1'b1;
        r.clauses[k] = c;
        k++;
      end
    end
    r.len = FORMULA_LEN_W'(k);
  endfunction

  function automatic logic has_empty(input formula f);
    logic e = 1'b0;
    for (int i = 0; i < int'(f.len); i++)
      if (f.clauses[i].len == '0) e = 1'b1;
    return e;
  endfunction

  function automatic void record_model(input int depth);
    ref_set = '0; ref_val = '0;
    for (int k = 0; k < depth; k++) begin
      ref_set[path_num[k]] = 1'b1;
      ref_val[path_num[k]] = path_val[k][0];
    end
  endfunction

  function automatic logic model_satisfies(input formula f, input logic [number_literal:0] s,
                                           input logic [number_literal:0] v);
    logic all_ok = 1'b1;
    logic hit;
    for (int i = 0; i < int'(f.len); i++) begin
      hit = 1'b0;
      for (int j = 0; j < int'(f.clauses[i].len); j++)
        if (s[f.clauses[i].lits[j].num] && (v[f.clauses[i].lits[j].num] == f.clauses[i].lits[j].val))
          hit = 1'b1;
      if (!hit) all_ok = 1'b0;
    end
    return all_ok;
  endfunction

  // Depth-first DPLL: first literal of first clause, true before false
  function automatic void ref_solve(input formula root, input int mode);
    formula lvl_f [8];
    int     lvl_n [8];
    int     lvl_try [8];
    int     depth, v;
    formula r;
    logic   conf, fin;
    ref_decisions = 0; ref_sat = 1'b0; ref_err = 1'b0; ref_set = '0; ref_val = '0;
    ref_trivial = (root.len == '0) || has_empty(root);
    if (root.len == '0) begin ref_sat = 1'b1; return; end
    if (has_empty(root)) return;
    depth = 0; lvl_f[0] = root; lvl_try[0] = 0;
    lvl_n[0] = int'(root.clauses[0].lits[0].num);
    if (lvl_n[0] == 0 || lvl_n[0] > number_literal) begin ref_err = 1'b1; return; end
    fin = 1'b0;
    for (int guard = 0; guard < 10000 && !fin; guard++) begin
      if (lvl_try[depth] == 2) begin
        if (depth == 0) fin = 1'b1;
        else depth--;
      end else begin
        v = (lvl_try[depth] == 0) ? 1 : 0;
        lvl_try[depth]++;
        ref_decisions++;
        path_num[depth] = lvl_n[depth];
        path_val[depth] = v;
        if (mode == 2) begin r = lvl_f[depth]; conf = 1'b0; end
        else bench_simplify(lvl_f[depth], lvl_n[depth], v, r, conf);
        if (!conf) begin
          if (r.len == '0) begin
            ref_sat = 1'b1; record_model(depth + 1); fin = 1'b1;
          end else begin
            depth++;
            lvl_f[depth] = r; lvl_try[depth] = 0;
            lvl_n[depth] = int'(r.clauses[0].lits[0].num);
            if (lvl_n[depth] == 0 || lvl_n[depth] > number_literal || depth == formula_stack_size) begin
              ref_err = 1'b1; fin = 1'b1;
            end
          end
        end
      end
    end
  endfunction

  // Simplifier stand-in: answers each request after a latency, or a forced stray ack
  initial begin
    int   lat_left = 0;
    logic acked = 1'b0;
    simp_ack = 1'b0; simp_conflict = 1'b0; simp_result = '0;
    forever begin
      @(negedge clk);
      simp_ack = 1'b0;
      if (force_cnt != force_done) begin
        force_done = force_cnt;
        simp_ack = 1'b1; simp_conflict = 1'b0; simp_result = '0;
      end else if (resp_mode != 0 && simp_req && !acked) begin
        if (lat_left > 0) lat_left--;
        else begin
          if (resp_mode == 2) begin simp_result = simp_formula; simp_conflict = 1'b0; end
          else bench_simplify(simp_formula, int'(simp_lit.num), int'(simp_lit.val), simp_result, simp_conflict);
          simp_ack = 1'b1; acked = 1'b1;
        end
      end
      if (!simp_req) begin
        acked = 1'b0;
        lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
    end
  end

  // Handshake monitor: operands stable while waiting, req held until ack, dropped right after it
  initial begin
    logic   prev_req = 1'b0, prev_ack = 1'b0;
    formula prev_f = '0;
    lit     prev_l = '0;
    forever begin
      @(negedge clk);
      #1;
      if (simp_req && !prev_req) req_rises++;
      if (simp_req && prev_req && !prev_ack && ((simp_formula !== prev_f) || (simp_lit !== prev_l))) proto_viol++;
      if (prev_req && !simp_req && !prev_ack) proto_viol++;
      if (prev_req && prev_ack && simp_req) proto_viol++;
      prev_req = simp_req; prev_ack = simp_ack; prev_f = simp_formula; prev_l = simp_lit;
    end
  end

  task automatic clear_fb();
    fb = '0;
  endtask

  task automatic add_clause(input int a, input int b = 0, input int c = 0);
    int l [3];
    int idx, n;
    l[0] = a; l[1] = b; l[2] = c;
    idx = int'(fb.len); n = 0;
    for (int j = 0; j < 3; j++) begin
      if (l[j] != 0) begin
        fb.clauses[idx].lits[n].num = LIT_NUM_W'((l[j] > 0) ? l[j] : -l[j]);
        fb.clauses[idx].lits[n].val = (l[j] > 0);
        n++;
      end
    end
    fb.clauses[idx].len = CLAUSE_LEN_W'(n);
    fb.len = FORMULA_LEN_W'(idx + 1);
  endtask

  task automatic gen_random(output formula f);
    int nv, nc, len, v;
    logic [7:0] used;
    f = '0;
    nv = $urandom_range(3, 6);
    nc = $urandom_range(1, number_clauses);
    f.len = FORMULA_LEN_W'(nc);
    for (int i = 0; i < nc; i++) begin
      len = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 3));
      used = '0;
      for (int j = 0; j < len; j++) begin
        do v = $urandom_range(1, nv); while (used[v]);
        used[v] = 1'b1;
        f.clauses[i].lits[j].num = LIT_NUM_W'(v);
        f.clauses[i].lits[j].val = 1'($urandom_range(0, 1));
      end
      f.clauses[i].len = CLAUSE_LEN_W'(len);
    end
  endtask

  // Run one search on f and compare every reported result with the reference
  task automatic apply_stimulus(input formula f, input string tag);
    int cyc, first_req, rise0, viol0;
    ref_solve(f, resp_mode);
    @(negedge clk);
    rise0 = req_rises; viol0 = proto_viol;
    formula_in = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0; formula_in = '1;
    cyc = 1; first_req = 0;
    while (!done && cyc < LIMIT) begin
      if (simp_req && first_req == 0) first_req = cyc;
      @(negedge clk);
      cyc++;
    end
    check_output({tag, "_done_in_time"}, 64'(cyc < LIMIT), 64'd1);
    check_output({tag, "_sat"}, 64'(sat), 64'(ref_sat));
    check_output({tag, "_err"}, 64'(err), 64'(ref_err));
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_model_set"}, 64'(model_set), 64'(ref_set));
    check_output({tag, "_model_val"}, 64'(model_val), 64'(ref_val));
    check_output({tag, "_decisions"}, 64'(decisions), 64'(ref_decisions));
    #2;
    check_output({tag, "_req_count"}, 64'(req_rises - rise0), 64'(ref_decisions));
    check_output({tag, "_handshake"}, 64'(proto_viol - viol0), 64'd0);
    if (ref_trivial) check_output({tag, "_trivial_latency"}, 64'(cyc), 64'd2);
    if (ref_decisions > 0) check_output({tag, "_first_req_latency"}, 64'(first_req), 64'd4);
    if (ref_sat) check_output({tag, "_model_sound"}, 64'(model_satisfies(f, model_set, model_val)), 64'd1);
  endtask

  task automatic reset_mid_search();
    logic seen = 1'b0;
    resp_mode = 0;
    clear_fb(); add_clause(1, 2);
    @(negedge clk);
    formula_in = fb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (simp_req) seen = 1'b1;
      else @(negedge clk);
    end
    check_output("rst_reached_wait", 64'(seen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_cnt++;
    repeat (3) @(negedge clk);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_req", 64'(simp_req), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_decisions", 64'(decisions), 64'd0);
    resp_mode = 1;
  endtask

  initial begin
    formula rf;
    rst = 1'b1; start = 1'b0; formula_in = '0;
    repeat (2) @(negedge clk);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_req", 64'(simp_req), 64'd0);
    check_output("reset_sat_err", 64'({sat, err}), 64'd0);
    check_output("reset_model", 64'({model_set, model_val}), 64'd0);
    check_output("reset_decisions", 64'(decisions), 64'd0);
    rst = 1'b0;

    clear_fb();
    apply_stimulus(fb, "empty_formula");

    clear_fb(); add_clause(0); add_clause(1);
    apply_stimulus(fb, "empty_clause");

    fixed_lat = 3;
    clear_fb(); add_clause(1);
    apply_stimulus(fb, "unit_x1");
    fixed_lat = -1;

    clear_fb(); add_clause(1); add_clause(-1, 2); add_clause(-2);
    apply_stimulus(fb, "three_clause_unsat");

    clear_fb();
    add_clause(-1, 2); add_clause(-2, 3); add_clause(-3, 4);
    add_clause(-4, 5); add_clause(-5); add_clause(1);
    apply_stimulus(fb, "chain_depth5");

    clear_fb(); add_clause(7);
    apply_stimulus(fb, "bad_literal");

    resp_mode = 2;
    clear_fb(); add_clause(1, 2);
    apply_stimulus(fb, "overflow");
    resp_mode = 1;

    reset_mid_search();
    clear_fb(); add_clause(1, -2); add_clause(2, 3);
    apply_stimulus(fb, "after_reset");

    for (int t = 0; t < 40; t++) begin
      gen_random(rf);
      apply_stimulus(rf, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
